// File: rtl/neuron_preact_mac.sv
// neuron_preact_mac: streams Q8.8 (x, w) pairs, accumulates x*w at full precision,
// then adds a bias, rounds half toward +inf and saturates back to Q8.8.
//   clk, rst (async, active-low)
//   in_valid/in_ready, x_in, w_in, in_last, bias : input beat handshake
//   y_out, valid_out, sat_out                    : one-cycle result pulse to the sigmoid
module neuron_preact_mac #(
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 40,
    parameter int DATA_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic signed [DATA_W-1:0] w_in,
    input  logic                     in_last,
    input  logic signed [DATA_W-1:0] bias,
    output logic signed [DATA_W-1:0] y_out,
    output logic                     valid_out,
    output logic                     sat_out
);
    localparam int PROD_W = 2 * DATA_W;
    localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(1) << (FRAC_BITS - 1);

    typedef enum logic [1:0] {ACC, DRAIN, ROUND} state_t;

    state_t                    state_q, state_d;
    logic signed [PROD_W-1:0]  prod_q, prod_d;
    logic                      prod_valid_q, prod_valid_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [DATA_W-1:0]  bias_q, bias_d;
    logic signed [DATA_W-1:0]  y_q, y_d;
    logic                      valid_q, valid_d;
    logic                      sat_q, sat_d;

    logic                      accept;
    logic signed [ACC_W-1:0]   prod_ext, bias_ext, sum, rnd;
    logic                      hi, lo;
    logic signed [DATA_W-1:0]  y_sat;

    assign in_ready  = state_q == ACC;
    assign accept    = in_valid && in_ready;
    assign y_out     = y_q;
    assign valid_out = valid_q;
    assign sat_out   = sat_q;

    always_comb begin
        prod_ext = {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
        bias_ext = {{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q};
        sum      = acc_q + (bias_ext <<< FRAC_BITS);
        rnd      = (sum + HALF) >>> FRAC_BITS;
        hi       = rnd > Y_MAX;
        lo       = rnd < Y_MIN;
        y_sat    = hi ? Y_MAX[DATA_W-1:0] : lo ? Y_MIN[DATA_W-1:0] : rnd[DATA_W-1:0];
    end

    always_comb begin
        state_d      = state_q == ACC   ? ((accept && in_last) ? DRAIN : ACC) :
                       state_q == DRAIN ? ROUND : ACC;
        prod_d       = accept ? x_in * w_in : prod_q;
        prod_valid_d = accept;
        bias_d       = (accept && in_last) ? bias : bias_q;
        // The last product lands during DRAIN, so ROUND only ever sees the finished sum.
        acc_d        = state_q == ROUND ? '0 : prod_valid_q ? acc_q + prod_ext : acc_q;
        valid_d      = state_q == ROUND;
        y_d          = state_q == ROUND ? y_sat : y_q;
        sat_d        = state_q == ROUND ? (hi || lo) : sat_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ACC;
            prod_q       <= '0;
            prod_valid_q <= 1'b0;
            acc_q        <= '0;
            bias_q       <= '0;
            y_q          <= '0;
            valid_q      <= 1'b0;
            sat_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            prod_q       <= prod_d;
            prod_valid_q <= prod_valid_d;
            acc_q        <= acc_d;
            bias_q       <= bias_d;
            y_q          <= y_d;
            valid_q      <= valid_d;
            sat_q        <= sat_d;
        end
    end
endmodule

// File: tb/tb_neuron_preact_mac.sv
// tb_neuron_preact_mac: directed self-checking bench for neuron_preact_mac.
module tb_neuron_preact_mac;
    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] x_in, w_in, bias;
    logic               in_last;
    logic signed [15:0] y_out;
    logic               valid_out;
    logic               sat_out;
    int                 tests = 0;
    int                 fails = 0;

    neuron_preact_mac dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .w_in(w_in), .in_last(in_last), .bias(bias),
        .y_out(y_out), .valid_out(valid_out), .sat_out(sat_out)
    );

    always #5 clk = ~clk;

    // Called on a falling edge; returns on the falling edge after the accepting rising edge.
    task automatic beat(input logic signed [15:0] x, input logic signed [15:0] w,
                        input logic last, input logic signed [15:0] b);
        int n = 0;
        x_in = x; w_in = w; in_last = last; bias = b; in_valid = 1'b1;
        while (!in_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10) begin
            tests++; fails++;
            $display("FAIL beat_accept: in_ready=%0d after %0d cycles, required 1", in_ready, n);
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Counts falling edges until valid_out is seen (0 if already high).
    task automatic wait_result(output int k);
        k = 0;
        while (!valid_out && k < 10) begin
            @(negedge clk);
            k++;
        end
        if (k >= 10) begin
            tests++; fails++;
            $display("FAIL result_timeout: valid_out=%0d after %0d cycles, required 1", valid_out, k);
        end
    endtask

    task automatic test_reset();
        int k;
        tests++; if (valid_out !== 1'b0 || y_out !== 16'sd0 || sat_out !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_state: valid=%0d y=%0d sat=%0d ready=%0d, required 0 0 0 1", valid_out, y_out, sat_out, in_ready);
        end
        beat(256, 256, 1'b1, 0);
        wait_result(k);
        tests++; if (y_out !== 16'sd256) begin
            fails++; $display("FAIL reset_pre_result: y=%0d, required 256", y_out);
        end
        @(negedge clk);
        beat(256, 256, 1'b0, 0);
        beat(1024, 1024, 1'b0, 0);
        rst = 1'b0;
        #1;
        tests++; if (valid_out !== 1'b0 || y_out !== 16'sd0 || sat_out !== 1'b0) begin
            fails++; $display("FAIL reset_async: valid=%0d y=%0d sat=%0d, required 0 0 0", valid_out, y_out, sat_out);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests++; if (in_ready !== 1'b1 || valid_out !== 1'b0 || y_out !== 16'sd0) begin
            fails++; $display("FAIL reset_release: ready=%0d valid=%0d y=%0d, required 1 0 0", in_ready, valid_out, y_out);
        end
        beat(256, 256, 1'b1, 0);
        wait_result(k);
        tests++; if (y_out !== 16'sd256 || k != 2) begin
            fails++; $display("FAIL reset_no_residue: y=%0d lat=%0d, required 256 2", y_out, k);
        end
        @(negedge clk);
    endtask

    task automatic test_single();
        beat(256, 512, 1'b1, 128);
        tests++; if (in_ready !== 1'b0 || valid_out !== 1'b0) begin
            fails++; $display("FAIL single_drain: ready=%0d valid=%0d, required 0 0", in_ready, valid_out);
        end
        @(negedge clk);
        tests++; if (in_ready !== 1'b0 || valid_out !== 1'b0) begin
            fails++; $display("FAIL single_round: ready=%0d valid=%0d, required 0 0", in_ready, valid_out);
        end
        @(negedge clk);
        tests++; if (in_ready !== 1'b1 || valid_out !== 1'b1 || y_out !== 16'sd640 || sat_out !== 1'b0) begin
            fails++; $display("FAIL single_result: ready=%0d valid=%0d y=%0d sat=%0d, required 1 1 640 0", in_ready, valid_out, y_out, sat_out);
        end
        @(negedge clk);
        tests++; if (valid_out !== 1'b0 || y_out !== 16'sd640) begin
            fails++; $display("FAIL single_pulse: valid=%0d y=%0d, required 0 640", valid_out, y_out);
        end
    endtask

    task automatic test_dot();
        int k;
        for (int i = 0; i < 4; i++) beat(256, 64, i == 3, -256);
        // Hold a non-last beat through DRAIN/ROUND; it must not be taken.
        x_in = 256; w_in = 256; in_last = 1'b0; in_valid = 1'b1;
        wait_result(k);
        in_valid = 1'b0;
        tests++; if (y_out !== 16'sd0 || sat_out !== 1'b0 || k != 2) begin
            fails++; $display("FAIL dot_result: y=%0d sat=%0d lat=%0d, required 0 0 2", y_out, sat_out, k);
        end
        @(negedge clk);
        beat(256, 256, 1'b1, 0);
        wait_result(k);
        tests++; if (y_out !== 16'sd256) begin
            fails++; $display("FAIL dot_held_not_consumed: y=%0d, required 256", y_out);
        end
        @(negedge clk);
    endtask

    task automatic test_round();
        logic signed [15:0] ws [3] = '{16'sd128, -16'sd128, -16'sd129};
        logic signed [15:0] ys [3] = '{16'sd1, 16'sd0, -16'sd1};
        int k;
        for (int i = 0; i < 3; i++) begin
            beat(1, ws[i], 1'b1, 0);
            wait_result(k);
            tests++; if (y_out !== ys[i] || sat_out !== 1'b0) begin
                fails++; $display("FAIL round_%0d: y=%0d sat=%0d, required %0d 0", i, y_out, sat_out, ys[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sat();
        int k;
        for (int i = 0; i < 4; i++) beat(32767, 32767, i == 3, 0);
        wait_result(k);
        tests++; if (y_out !== 16'sd32767 || sat_out !== 1'b1) begin
            fails++; $display("FAIL sat_pos: y=%0d sat=%0d, required 32767 1", y_out, sat_out);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) beat(-32768, 32767, i == 3, 0);
        wait_result(k);
        tests++; if (y_out !== -16'sd32768 || sat_out !== 1'b1) begin
            fails++; $display("FAIL sat_neg: y=%0d sat=%0d, required -32768 1", y_out, sat_out);
        end
        @(negedge clk);
        beat(256, 256, 1'b1, 0);
        wait_result(k);
        tests++; if (sat_out !== 1'b0) begin
            fails++; $display("FAIL sat_clear: sat=%0d, required 0", sat_out);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int p1 = 0, p2 = 0, stage = 1;
        logic signed [15:0] y1 = 0, y2 = 0;
        logic acc;
        x_in = 256; w_in = 256; in_last = 1'b1; bias = 0; in_valid = 1'b1;
        @(negedge clk);
        x_in = 512; w_in = 256; in_last = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            if (valid_out) begin
                if (p1 == 0) begin p1 = i; y1 = y_out; end
                else if (p2 == 0) begin p2 = i; y2 = y_out; end
            end
            acc = in_valid && in_ready;
            @(negedge clk);
            if (acc && stage == 1) begin stage = 2; in_last = 1'b1; end
            else if (acc && stage == 2) begin stage = 3; in_valid = 1'b0; in_last = 1'b0; end
        end
        tests++; if (p1 != 3 || y1 !== 16'sd256) begin
            fails++; $display("FAIL b2b_first: cycle=%0d y=%0d, required 3 256", p1, y1);
        end
        tests++; if (p2 != 7 || y2 !== 16'sd1024) begin
            fails++; $display("FAIL b2b_second: cycle=%0d y=%0d, required 7 1024", p2, y2);
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; x_in = 0; w_in = 0; bias = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_dot();
        test_round();
        test_sat();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
